// File: rtl/i2c_xfer_sched_if.sv
// Wishbone master bundle between the transfer scheduler and the I2C core.
// Signal names follow the scheduler's bus pin names.
interface i2c_xfer_sched_if;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_we_o;
    logic       m_stb_o;
    logic       m_cyc_o;
    logic       m_ack_i;

    modport master (
        output m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/i2c_xfer_sched.sv
// Two-requester I2C register transfer scheduler driving a Wishbone
// I2C master core: init, round-robin grant, byte sequencing, status.
module i2c_xfer_sched #(
    parameter logic [15:0] PRESCALE = 16'h0063,
    parameter int          POLL_MAX = 1023
) (
    input  logic             wb_clk_i,
    input  logic             arst_i,
    i2c_xfer_sched_if.master wb,
    input  logic [1:0]       req_i,
    input  logic [1:0]       rnw_i,
    input  logic [13:0]      dev_i,
    input  logic [15:0]      reg_i,
    input  logic [15:0]      wdat_i,
    output logic [1:0]       done_o,
    output logic [3:0]       err_o,
    output logic [7:0]       rdat_o,
    output logic             busy_o
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_IDLE   = 4'd1;
    localparam logic [3:0] S_WR_TXR = 4'd2;
    localparam logic [3:0] S_WR_CR  = 4'd3;
    localparam logic [3:0] S_POLL   = 4'd4;
    localparam logic [3:0] S_CHECK  = 4'd5;
    localparam logic [3:0] S_STOP   = 4'd6;
    localparam logic [3:0] S_RD_RXR = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]  r_state;
    logic [1:0]  r_init;
    logic [1:0]  r_step;
    logic [15:0] r_poll;
    logic        r_sp;
    logic        r_gnt;
    logic        r_last;
    logic        r_rnw;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdat;
    logic [7:0]  r_rx;
    logic [7:0]  r_rdat;
    logic [1:0]  r_code;
    logic [3:0]  r_err;
    logic        r_al;
    logic        r_nack;
    logic        r_stb;
    logic        r_we;
    logic [2:0]  r_adr;
    logic [7:0]  r_dat;

    logic        w_ack;
    logic        w_gnt;
    logic        w_final;
    logic        w_tmo;
    logic [15:0] w_poll_nxt;
    logic [7:0]  w_txr;
    logic [7:0]  w_cr;
    logic        w_bus;
    logic        w_we;
    logic [2:0]  w_adr;
    logic [7:0]  w_dat;
    logic [3:0]  w_err;

    assign w_ack      = r_stb & wb.m_ack_i;
    assign w_poll_nxt = r_poll + 16'd1;
    assign w_tmo      = w_poll_nxt >= 16'(POLL_MAX);
    // Lone request wins; contention goes to whoever was not served last.
    assign w_gnt      = (&req_i) ? ~r_last : req_i[1];
    assign w_final    = r_rnw ? (r_step == 2'd3) : (r_step == 2'd2);

    always_comb begin
        w_txr = {r_dev, 1'b0};
        w_cr  = 8'h90;
        unique case (r_step)
            2'd1: begin
                w_txr = r_reg;
                w_cr  = 8'h10;
            end
            2'd2: begin
                w_txr = r_rnw ? {r_dev, 1'b1} : r_wdat;
                w_cr  = r_rnw ? 8'h90 : 8'h50;
            end
            2'd3: begin
                w_txr = 8'h00;
                w_cr  = 8'h68;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_bus = 1'b1;
        w_we  = 1'b1;
        w_adr = 3'd4;
        w_dat = 8'h00;
        unique case (r_state)
            S_INIT: begin
                w_adr = {1'b0, r_init};
                w_dat = (r_init == 2'd0) ? PRESCALE[7:0] :
                        (r_init == 2'd1) ? PRESCALE[15:8] : 8'h80;
            end
            S_WR_TXR: begin
                w_adr = 3'd3;
                w_dat = w_txr;
            end
            S_WR_CR:  w_dat = w_cr;
            S_POLL:   w_we  = 1'b0;
            S_STOP: begin
                w_we  = ~r_sp;
                w_dat = 8'h40;
            end
            S_RD_RXR: begin
                w_adr = 3'd3;
                w_we  = 1'b0;
            end
            default:  w_bus = 1'b0;
        endcase
    end

    always_comb begin
        w_err = r_err;
        if (r_gnt) w_err[3:2] = r_code;
        else       w_err[1:0] = r_code;
    end

    assign wb.m_adr_o = r_adr;
    assign wb.m_dat_o = r_dat;
    assign wb.m_we_o  = r_we;
    assign wb.m_stb_o = r_stb;
    assign wb.m_cyc_o = r_stb;
    assign done_o     = (r_state == S_DONE) ? {r_gnt, ~r_gnt} : 2'b00;
    assign err_o      = (r_state == S_DONE) ? w_err : r_err;
    assign rdat_o     = (r_state == S_DONE) ? r_rx : r_rdat;
    assign busy_o     = arst_i & (r_state != S_IDLE);

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state <= S_INIT;
            r_init  <= 2'd0;
            r_step  <= 2'd0;
            r_poll  <= 16'd0;
            r_sp    <= 1'b0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_rnw   <= 1'b0;
            r_dev   <= 7'd0;
            r_reg   <= 8'd0;
            r_wdat  <= 8'd0;
            r_rx    <= 8'd0;
            r_rdat  <= 8'd0;
            r_code  <= 2'd0;
            r_err   <= 4'd0;
            r_al    <= 1'b0;
            r_nack  <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= 3'd0;
            r_dat   <= 8'd0;
        end else begin
            // Each access launches one cycle after the previous ack drops stb.
            if (w_bus && !r_stb) begin
                r_stb <= 1'b1;
                r_adr <= w_adr;
                r_dat <= w_dat;
                r_we  <= w_we;
            end
            if (w_ack) r_stb <= 1'b0;

            unique case (r_state)
                S_INIT: if (w_ack) begin
                    r_init <= r_init + 2'd1;
                    if (r_init == 2'd2) begin
                        r_init  <= 2'd0;
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: if (|req_i) begin
                    r_gnt   <= w_gnt;
                    r_rnw   <= rnw_i[w_gnt];
                    r_dev   <= w_gnt ? dev_i[13:7] : dev_i[6:0];
                    r_reg   <= w_gnt ? reg_i[15:8] : reg_i[7:0];
                    r_wdat  <= w_gnt ? wdat_i[15:8] : wdat_i[7:0];
                    r_step  <= 2'd0;
                    r_code  <= 2'd0;
                    r_rx    <= 8'd0;
                    r_sp    <= 1'b0;
                    r_state <= S_WR_TXR;
                end
                S_WR_TXR: if (w_ack) r_state <= S_WR_CR;
                S_WR_CR: if (w_ack) begin
                    r_poll  <= 16'd0;
                    r_state <= S_POLL;
                end
                S_POLL: if (w_ack) begin
                    r_al   <= wb.m_dat_i[5];
                    r_nack <= wb.m_dat_i[7];
                    r_poll <= w_poll_nxt;
                    if (!wb.m_dat_i[1]) begin
                        r_state <= S_CHECK;
                    end else if (w_tmo) begin
                        r_code  <= 2'b11;
                        r_state <= S_STOP;
                    end
                end
                S_CHECK: begin
                    if (r_al) begin
                        r_code  <= 2'b10;
                        r_state <= S_DONE;
                    end else if (r_nack && !w_final) begin
                        r_code  <= 2'b01;
                        r_state <= S_STOP;
                    end else if (w_final) begin
                        r_state <= r_rnw ? S_RD_RXR : S_DONE;
                    end else begin
                        r_step  <= r_step + 2'd1;
                        // The read's final byte has no TXR load.
                        r_state <= (r_rnw && r_step == 2'd2) ? S_WR_CR : S_WR_TXR;
                    end
                end
                S_STOP: if (w_ack) begin
                    if (!r_sp) begin
                        r_sp   <= 1'b1;
                        r_poll <= 16'd0;
                    end else begin
                        r_poll <= w_poll_nxt;
                        if (!wb.m_dat_i[1] || w_tmo) r_state <= S_DONE;
                    end
                end
                S_RD_RXR: if (w_ack) begin
                    r_rx    <= wb.m_dat_i;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (r_gnt) r_err[3:2] <= r_code;
                    else       r_err[1:0] <= r_code;
                    r_rdat  <= r_rx;
                    r_last  <= r_gnt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule

// File: doc/i2c_xfer_sched.md
I2C_XFER_SCHED -- requirements
Module: i2c_xfer_sched

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'h0063, the value written to the I2C master prescale registers during initialisation.
REQ-002 SHALL have parameter POLL_MAX, default 1023, the maximum number of status polls per byte before timeout.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port arst_i, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port m_adr_o, output, 3 bits: I2C master register address (0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR).
REQ-006 SHALL have port m_dat_o, output, 8 bits: write data to the I2C master.
REQ-007 SHALL have port m_dat_i, input, 8 bits: read data from the I2C master.
REQ-008 SHALL have ports m_we_o, m_stb_o and m_cyc_o, output, 1 bit each: Wishbone write enable, strobe and cycle.
REQ-009 SHALL have port m_ack_i, input, 1 bit: Wishbone acknowledge.
REQ-010 SHALL have port req_i, input, 2 bits: per-requester transfer request.
REQ-011 SHALL have port rnw_i, input, 2 bits: per-requester direction, 1 = read, 0 = write.
REQ-012 SHALL have port dev_i, input, 14 bits: per-requester 7-bit device address; requester n uses [7n+6:7n].
REQ-013 SHALL have ports reg_i and wdat_i, input, 16 bits each: per-requester register address and write byte; requester n uses [8n+7:8n].
REQ-014 SHALL have port done_o, output, 2 bits: one-cycle completion pulse per requester.
REQ-015 SHALL have port err_o, output, 4 bits: per-requester status code, valid with done_o (00 ok, 01 NACK, 10 arbitration lost, 11 timeout).
REQ-016 SHALL have port rdat_o, output, 8 bits: read byte, valid with done_o.
REQ-017 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 SHALL be a state machine with states INIT, IDLE, WR_TXR, WR_CR, POLL, CHECK, STOP, RD_RXR and DONE.
REQ-019 SHALL, on leaving reset, perform three Wishbone writes in order (PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=8'h80) and then enter IDLE.
REQ-020 SHALL perform Wishbone accesses one at a time: stb/cyc asserted with stable adr/dat/we until the cycle m_ack_i=1, then deasserted for at least 1 cycle.
REQ-021 SHALL arbitrate only in IDLE: round-robin; a lone request wins; with both requesting, the requester not served last wins; the first grant after reset goes to requester 0.
REQ-022 SHALL latch the granted requester's rnw/dev/reg/wdat on grant; req_i changes after grant are ignored until DONE.
REQ-023 SHALL sequence a write as: TXR={dev,0}, CR=8'h90; TXR=reg, CR=8'h10; TXR=wdat, CR=8'h50.
REQ-024 SHALL sequence a read as: TXR={dev,0}, CR=8'h90; TXR=reg, CR=8'h10; TXR={dev,1}, CR=8'h90; CR=8'h68; then read RXR into rdat_o.
REQ-025 SHALL, after each CR write, repeatedly read SR (POLL) until SR[1] (TIP)=0, then evaluate in CHECK.
REQ-026 SHALL, in CHECK, act on SR[5] (AL)=1 first: go to DONE with err 10 and issue no STOP.
REQ-027 SHALL, in CHECK, act next on SR[7] (RxACK)=1 after any non-final byte: write CR=8'h40, poll TIP=0, then go to DONE with err 01.
REQ-028 SHALL ignore RxACK on the final read byte, since the core sends NACK there.
REQ-029 SHALL count polls per byte with a counter cleared at each CR write; on reaching POLL_MAX polls with TIP still 1, issue STOP as in REQ-027 and go to DONE with err 11.
REQ-030 SHALL, in DONE, pulse the granted done_o bit for 1 cycle, drive err_o and rdat_o, then return to IDLE.
REQ-031 SHALL hold err_o and rdat_o until the next DONE.
REQ-032 SHALL keep the other requester's done_o at 0 during DONE.

Reset
REQ-033 SHALL, while arst_i=0, drive m_stb_o, m_cyc_o, m_we_o, done_o and busy_o to 0, m_adr_o, m_dat_o, err_o and rdat_o to 0, and hold the state at INIT with the init step at 0.
REQ-034 SHALL, when reset is asserted mid-transfer, abandon the transfer with no done pulse and, after release, redo INIT.

Verification
REQ-035 Reset release with an acking slave SHALL produce exactly three writes (adr 0/8'h63, 1/8'h00, 2/8'h80) followed by busy_o=0.
REQ-036 A requester 0 write (dev 7'h50, reg 8'h12, data 8'hA5) with all ACKs SHALL produce TXR writes 8'hA0, 8'h12, 8'hA5 and CR writes 90, 10, 50, then done_o=01 with err 00.
REQ-037 A requester 1 read (dev 7'h50, reg 8'h34) with RXR=8'h5C SHALL produce CR sequence 90, 10, 90, 68, then done_o=10, rdat_o=8'h5C and err 00.
REQ-038 With req_i=11 held, grants SHALL alternate 0, 1, 0, 1 across four transfers.
REQ-039 With RxACK=1 after the address byte, the bench SHALL see CR=8'h40 issued and err 01.
REQ-040 With AL=1, the bench SHALL see no STOP and err 10.
REQ-041 With TIP stuck at 1, the bench SHALL see 1023 SR reads, then STOP and err 11.
